// File: rtl/srrc_upsampler.sv
// Symbol front end for the SRRC pulse shaper: Gray 4-ASK mapping, zero-stuffing by OSR,
// and a one-entry holding register whose empty slots are reported as underflow.
module srrc_upsampler #(
  parameter int                 OSR       = 4,
  parameter logic signed [7:0]  LVL_OUTER = 8'sd96,
  parameter logic signed [7:0]  LVL_INNER = 8'sd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [7:0]  symb_out,
  output logic        symb_strobe,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int            PW      = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          hold_valid_q, hold_valid_d;
  logic [1:0]    hold_sym_q, hold_sym_d;
  logic [7:0]    symb_out_q, symb_out_d;
  logic          symb_strobe_q, symb_strobe_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   underflow_cnt_q, underflow_cnt_d;

  logic slot, accept;

  function automatic logic [7:0] gray_map(input logic [1:0] s);
    logic [7:0] v;
    unique case (s)
      2'b00:   v = -LVL_OUTER;
      2'b01:   v = -LVL_INNER;
      2'b11:   v = LVL_INNER;
      default: v = LVL_OUTER;
    endcase
    return v;
  endfunction

  assign slot      = enable && (phase_q == '0);
  // A slot frees the register on the same edge, so a full register can still take a symbol then.
  assign sym_ready = !hold_valid_q || slot;
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    phase_d         = '0;
    hold_valid_d    = hold_valid_q;
    hold_sym_d      = hold_sym_q;
    symb_out_d      = '0;
    symb_strobe_d   = 1'b0;
    underflow_d     = 1'b0;
    underflow_cnt_d = underflow_cnt_q;

    if (enable)
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    if (slot) begin
      if (hold_valid_q) begin
        symb_out_d    = gray_map(hold_sym_q);
        symb_strobe_d = 1'b1;
        hold_valid_d  = 1'b0;
      end else begin
        underflow_d = 1'b1;
        if (underflow_cnt_q != 16'hFFFF)
          underflow_cnt_d = underflow_cnt_q + 16'd1;
      end
    end

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_sym_d   = sym_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q         <= '0;
      hold_valid_q    <= 1'b0;
      hold_sym_q      <= 2'b00;
      symb_out_q      <= '0;
      symb_strobe_q   <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      phase_q         <= phase_d;
      hold_valid_q    <= hold_valid_d;
      hold_sym_q      <= hold_sym_d;
      symb_out_q      <= symb_out_d;
      symb_strobe_q   <= symb_strobe_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign symb_out      = symb_out_q;
  assign symb_strobe   = symb_strobe_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;

endmodule

// File: doc/srrc_upsampler.md
Name: srrc_upsampler

Overview:
- Upstream stage of the 21-tap SRRC pulse-shaping filter.
- Accepts 2-bit symbols over a valid/ready handshake and maps them to signed 8-bit Gray-coded 4-ASK levels.
- Zero-stuffs the levels by OSR and drives the filter's 8-bit sample input once per clk.
- The filter has no handshake and consumes one sample every clock, so this block owns sample timing and flags starvation.

Parameters:
- OSR, 4, oversampling factor: samples per symbol; legal range 2..16.
- LVL_OUTER, 96, magnitude of the outer constellation points (signed 8-bit).
- LVL_INNER, 32, magnitude of the inner constellation points (signed 8-bit).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run control; when low the sample stream is frozen at zero.
- sym_in  in  2  symbol bits {b1,b0}.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  block can accept sym_in this cycle.
- symb_out  out  8  signed sample to the SRRC filter input.
- symb_strobe  out  1  high for the cycle symb_out carries a symbol (non-stuffed) sample.
- underflow  out  1  one-cycle pulse: a symbol slot arrived with no symbol held.
- underflow_cnt  out  16  saturating count of underflow events.

Behaviour:
- Reset values: symb_out=0, symb_strobe=0, underflow=0, underflow_cnt=0, phase=0, holding register empty. sym_ready is combinational and therefore reads 1 after reset.
- Reset asserted mid-operation discards any held symbol. A symbol offered during a reset cycle is not accepted.
- Gray mapping (two's complement):
  - 00 -> -LVL_OUTER (-96)
  - 01 -> -LVL_INNER (-32)
  - 11 -> +LVL_INNER (+32)
  - 10 -> +LVL_OUTER (+96)
- Phase counter:
  - counts 0..OSR-1 and wraps to 0; advances by one per clk while enable=1.
  - while enable=0 it is forced to 0.
- Holding register: one entry (hold_valid, hold_sym).
- sym_ready = !hold_valid || (enable && phase==0). Combinational, no dependency on sym_valid.
- A symbol is accepted on a rising edge where sym_valid && sym_ready. It is written to the holding register on that edge.
- Symbol slot (edge where enable=1 and phase==0):
  - If hold_valid: symb_out <= map(hold_sym), symb_strobe <= 1, holding register consumed.
  - Else: symb_out <= 0, symb_strobe <= 0, underflow <= 1, underflow_cnt <= underflow_cnt+1. The count saturates at 16'hFFFF.
- Consume and accept on the same edge: the new symbol refills the register, so hold_valid stays 1. Back-to-back symbols sustain one symbol per OSR clocks with no bubbles.
- Stuffed edges (enable=1, phase!=0): symb_out <= 0, symb_strobe <= 0, underflow <= 0.
- enable=0 edges: symb_out <= 0, symb_strobe <= 0, underflow <= 0. No underflow counting. The holding register keeps its content and may still fill if empty.
- Enable rising: the first edge with enable=1 is a symbol slot (phase=0).
- Latency: a symbol accepted at edge k appears on symb_out after the first later edge that is a symbol slot. Minimum is 1 clock: accepted at edge k, phase==0 at edge k+1. Maximum is OSR clocks while enabled.
- Output is registered. No combinational path from sym_in or sym_valid to symb_out.
- Resulting stream per symbol is level, 0, 0, 0 (for OSR=4), aligned to symb_strobe.

Test Plan:
- Reset release, enable=1, no symbols: symb_out=0 always; underflow pulses every 4th clk starting with the first edge; underflow_cnt reaches 3 after 12 clks.
- sym_valid held high with sequence 00,01,11,10 and enable=1: symb_out = -96,0,0,0,-32,0,0,0,+32,0,0,0,+96,0,0,0; symb_strobe aligned to each nonzero sample; underflow never asserted after the first symbol.
- Continuous valid stream: sym_ready low for exactly 3 of every 4 cycles once the holding register is full; one symbol accepted per 4 clks; no dropped or duplicated symbols over 64 random symbols checked against a reference mapper.
- Symbol accepted while enable=0, then enable raised: the first enabled edge outputs the held level (e.g. 10 -> +96) with symb_strobe=1; underflow_cnt unchanged.
- Assert reset for one cycle with a symbol held and the counter at 5: all outputs return to reset values, the held symbol is discarded, and the next slot reports underflow with underflow_cnt=1.
- Force underflow_cnt to 16'hFFFE and starve for 3 slots: the counter stops at 16'hFFFF; the underflow pulse still asserts each slot.
